// File: rtl/bw_io_ddr_impupd_ctl.sv
// Impedance/vref update scheduler for one DDR byte lane.
// Applies calibration codes to the pads only while the lane is quiet.
//
// Ports:
//   clk, reset          lane clock, async active-high reset
//   cal_vld/cal_ack     four-phase request/acknowledge from calibration
//   cal_cbu/cbd/vref    requested pull-up, pull-down and vref codes
//   oe, odt_enable      lane activity; idle when both are low
//   cbu/cbd/vrefcode    registered codes driven to the pad cells
//   upd_stall           asks the DDR controller to idle the lane
//   upd_busy            an update is in flight (state not IDLE)
//   upd_cnt             number of applied updates, wraps at 256
module bw_io_ddr_impupd_ctl #(
    parameter int QUIET_CYC = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cal_vld,
    input  logic [7:0] cal_cbu,
    input  logic [7:0] cal_cbd,
    input  logic [7:0] cal_vref,
    output logic       cal_ack,
    input  logic       oe,
    input  logic       odt_enable,
    output logic [7:0] cbu,
    output logic [7:0] cbd,
    output logic [7:0] vrefcode,
    output logic       upd_stall,
    output logic       upd_busy,
    output logic [7:0] upd_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        APPLY,
        ACK
    } state_e;

    localparam logic [3:0] QLAST = 4'(QUIET_CYC - 1);
    localparam logic [7:0] TLIM  = 8'(TIMEOUT);
    localparam logic [7:0] TPRE  = 8'(TIMEOUT - 1);

    state_e     state_q;
    logic [7:0] pend_cbu_q;
    logic [7:0] pend_cbd_q;
    logic [7:0] pend_vref_q;
    logic [3:0] quiet_q;
    logic [7:0] timer_q;

    logic idle;
    logic quiet_hit;
    logic same;

    assign idle      = ~oe & ~odt_enable;
    assign quiet_hit = idle && (quiet_q == QLAST);
    assign same      = (cal_cbu == cbu) && (cal_cbd == cbd)
                    && (cal_vref == vrefcode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_cbu_q  <= 8'h00;
            pend_cbd_q  <= 8'h00;
            pend_vref_q <= 8'h00;
            quiet_q     <= 4'd0;
            timer_q     <= 8'd0;
            cbu         <= 8'h0F;
            cbd         <= 8'h0F;
            vrefcode    <= 8'h80;
            cal_ack     <= 1'b0;
            upd_stall   <= 1'b0;
            upd_busy    <= 1'b0;
            upd_cnt     <= 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cal_vld) begin
                        pend_cbu_q  <= cal_cbu;
                        pend_cbd_q  <= cal_cbd;
                        pend_vref_q <= cal_vref;
                        quiet_q     <= 4'd0;
                        timer_q     <= 8'd0;
                        upd_busy    <= 1'b1;
                        // Unchanged codes skip the quiet wait entirely;
                        // the acknowledge follows one edge later in ACK.
                        state_q     <= same ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    timer_q <= (timer_q == TLIM) ? TLIM : timer_q + 8'd1;
                    if (quiet_hit) begin
                        // Quiet wins over a coincident timeout: no stall.
                        state_q <= APPLY;
                    end else begin
                        quiet_q <= idle ? quiet_q + 4'd1 : 4'd0;
                        if (timer_q == TPRE) begin
                            upd_stall <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    // Committed on the previous edge; lane activity
                    // arriving now does not cancel the load.
                    cbu       <= pend_cbu_q;
                    cbd       <= pend_cbd_q;
                    vrefcode  <= pend_vref_q;
                    upd_cnt   <= upd_cnt + 8'd1;
                    upd_stall <= 1'b0;
                    cal_ack   <= 1'b1;
                    state_q   <= ACK;
                end
                ACK: begin
                    if (!cal_vld) begin
                        cal_ack  <= 1'b0;
                        upd_busy <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        cal_ack  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_io_ddr_impupd_ctl.sv
// Self-checking bench for bw_io_ddr_impupd_ctl.
// Expected pad codes and handshake derived from a quiet-window model.
module tb_bw_io_ddr_impupd_ctl;

    localparam int Q = 4;
    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cal_vld = 1'b0;
    logic [7:0] cal_cbu = 8'h00;
    logic [7:0] cal_cbd = 8'h00;
    logic [7:0] cal_vref = 8'h00;
    logic       cal_ack;
    logic       oe = 1'b0;
    logic       odt_enable = 1'b0;
    logic [7:0] cbu;
    logic [7:0] cbd;
    logic [7:0] vrefcode;
    logic       upd_stall;
    logic       upd_busy;
    logic [7:0] upd_cnt;

    int total = 0;
    int bad = 0;

    logic [7:0] m_cbu = 8'h0F;
    logic [7:0] m_cbd = 8'h0F;
    logic [7:0] m_vref = 8'h80;
    logic [7:0] m_cnt = 8'd0;

    bw_io_ddr_impupd_ctl #(
        .QUIET_CYC(Q),
        .TIMEOUT  (T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cal_vld   (cal_vld),
        .cal_cbu   (cal_cbu),
        .cal_cbd   (cal_cbd),
        .cal_vref  (cal_vref),
        .cal_ack   (cal_ack),
        .oe        (oe),
        .odt_enable(odt_enable),
        .cbu       (cbu),
        .cbd       (cbd),
        .vrefcode  (vrefcode),
        .upd_stall (upd_stall),
        .upd_busy  (upd_busy),
        .upd_cnt   (upd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ack,
                           input logic e_stall, input logic e_busy);
        chk({tag, ".cbu"}, cbu, m_cbu);
        chk({tag, ".cbd"}, cbd, m_cbd);
        chk({tag, ".vref"}, vrefcode, m_vref);
        chk({tag, ".cnt"}, upd_cnt, m_cnt);
        chk({tag, ".ack"}, {7'd0, cal_ack}, {7'd0, e_ack});
        chk({tag, ".stall"}, {7'd0, upd_stall}, {7'd0, e_stall});
        chk({tag, ".busy"}, {7'd0, upd_busy}, {7'd0, e_busy});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_cbu  = 8'h0F;
        m_cbd  = 8'h0F;
        m_vref = 8'h80;
        m_cnt  = 8'd0;
    endtask

    // One full request. busy_mask bit m forces oe high for the edge m
    // after capture; otherwise lane activity is random at pct percent.
    // Apply happens on the first edge closing Q consecutive idle samples.
    task automatic xact(input logic [7:0] u, input logic [7:0] d,
                        input logic [7:0] v, input logic [63:0] busy_mask,
                        input int pct, input string tag);
        bit byp;
        bit quiet;
        bit e_stall;
        bit s[$];
        int m;
        byp = (u == m_cbu) && (d == m_cbd) && (v == m_vref);
        cal_vld  = 1'b1;
        cal_cbu  = u;
        cal_cbd  = d;
        cal_vref = v;
        oe         = busy_mask[0];
        odt_enable = 1'b0;
        tick();
        chk_all({tag, ".cap"}, 1'b0, 1'b0, 1'b1);
        if (byp) begin
            tick();
            chk_all({tag, ".byp"}, 1'b1, 1'b0, 1'b1);
        end else begin
            m = 0;
            quiet = 1'b0;
            while (!quiet) begin
                m++;
                if (m < 64 && busy_mask[m]) begin
                    oe         = 1'b1;
                    odt_enable = 1'b0;
                end else if (m > 60) begin
                    oe         = 1'b0;
                    odt_enable = 1'b0;
                end else begin
                    oe         = ($urandom_range(99) < pct);
                    odt_enable = ($urandom_range(99) < pct);
                end
                cal_cbu  = 8'($urandom);
                cal_cbd  = 8'($urandom);
                cal_vref = 8'($urandom);
                s.push_back(~oe & ~odt_enable);
                tick();
                quiet = (m >= Q);
                for (int j = 0; j < Q; j++) begin
                    if (m >= Q && !s[s.size() - 1 - j]) quiet = 1'b0;
                end
                e_stall = (m >= T) && (!quiet || m > T);
                chk_all($sformatf("%s.w%0d", tag, m), 1'b0, e_stall, 1'b1);
            end
            oe         = 1'($urandom);
            odt_enable = 1'($urandom);
            tick();
            m_cbu  = u;
            m_cbd  = d;
            m_vref = v;
            m_cnt  = m_cnt + 8'd1;
            chk_all({tag, ".apply"}, 1'b1, 1'b0, 1'b1);
        end
        repeat ($urandom_range(2)) begin
            tick();
            chk_all({tag, ".hold"}, 1'b1, 1'b0, 1'b1);
        end
        cal_vld = 1'b0;
        oe         = 1'b0;
        odt_enable = 1'b0;
        tick();
        chk_all({tag, ".drop"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with a live request: nothing may happen.
        reset    = 1'b1;
        cal_vld  = 1'b1;
        cal_cbu  = 8'h3C;
        cal_cbd  = 8'h2A;
        cal_vref = 8'h77;
        repeat (3) begin
            tick();
            chk_all("rst", 1'b0, 1'b0, 1'b0);
        end
        cal_vld = 1'b0;
        reset   = 1'b0;
        tick();
        chk_all("rst.rel", 1'b0, 1'b0, 1'b0);

        xact(8'h0F, 8'h0F, 8'h80, 64'd0, 0, "bypass");
        xact(8'h3C, 8'h2A, 8'h77, 64'd0, 0, "quiet");
        xact(8'h11, 8'h22, 8'h33, 64'h8, 0, "broken");
        xact(8'h44, 8'h55, 8'h66, 64'h1FFFFF, 0, "tmo");
        xact(8'h44, 8'h55, 8'h66, 64'd0, 0, "bypass2");

        for (int i = 0; i < 20; i++) begin
            xact(8'($urandom), 8'($urandom), 8'($urandom), 64'd0,
                 30, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a wait discards the pending codes.
        cal_vld  = 1'b1;
        cal_cbu  = 8'h55;
        cal_cbd  = 8'hAA;
        cal_vref = 8'h33;
        oe       = 1'b1;
        repeat (6) tick();
        chk("midw.busy", {7'd0, upd_busy}, 8'd1);
        reset = 1'b1;
        #1;
        model_reset();
        chk_all("midw.rst", 1'b0, 1'b0, 1'b0);
        cal_vld = 1'b0;
        oe      = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) begin
            tick();
            chk_all("midw.lost", 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 256; i++) begin
            xact(8'(i), ~8'(i), 8'($urandom), 64'd0, 10,
                 $sformatf("wrap%0d", i));
        end
        chk("wrap.cnt", upd_cnt, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bw_io_ddr_impupd_ctl.md
# bw_io_ddr_impupd_ctl

Impedance/vref update scheduler for one DDR byte lane's pad drivers. It accepts new pull-up, pull-down and vref codes from the impedance calibration engine over a four-phase handshake. New codes are applied to the pad-facing code registers only during a quiet window, when the lane is neither driving nor terminating. If the bus never goes quiet, it asks the DDR controller to stall traffic. It sits between the calibration FSM/DDR controller and the lane's driver/receiver pad cells.

## Interface
Parameters:
- QUIET_CYC, 4: consecutive idle cycles (oe=0 and odt_enable=0) required before applying; legal 1..15.
- TIMEOUT, 64: WAIT cycles before upd_stall is raised; legal QUIET_CYC+1..255.

Ports:
- clk  in  1  lane clock.
- reset  in  1  asynchronous, active-high reset.
- cal_vld  in  1  new codes valid; held until cal_ack, then dropped.
- cal_cbu  in  8  requested pull-up code, maps to pad cbu[8:1].
- cal_cbd  in  8  requested pull-down code, maps to pad cbd[8:1].
- cal_vref  in  8  requested vref code.
- cal_ack  out  1  four-phase acknowledge.
- oe  in  1  lane output-enable, as sent to the pads.
- odt_enable  in  1  lane ODT enable, as sent to the pads.
- cbu  out  8  registered pull-up code to pads.
- cbd  out  8  registered pull-down code to pads.
- vrefcode  out  8  registered vref code to pads.
- upd_stall  out  1  request to the DDR controller to idle the lane.
- upd_busy  out  1  update pending (state is not IDLE).
- upd_cnt  out  8  count of applied updates, wraps.

## Operation
- States: IDLE, WAIT, APPLY, ACK.
- Idle condition each cycle: idle = ~oe & ~odt_enable.
- **IDLE**
  - If cal_vld=1, capture cal_cbu/cal_cbd/cal_vref into pending registers.
  - If the pending codes equal the current cbu/cbd/vrefcode, go to ACK. This is the no-change bypass: no APPLY, upd_cnt unchanged.
  - Otherwise go to WAIT.
  - On the capture edge, clear the quiet counter and the timeout timer.
- **WAIT**
  - Timer increments every cycle and saturates at TIMEOUT.
  - Quiet counter increments when idle=1 and clears to 0 when idle=0.
  - When quiet counter = QUIET_CYC-1 and idle=1, go to APPLY.
  - When the timer reaches TIMEOUT, set upd_stall.
  - Remain in WAIT until the quiet condition is met, with or without the stall.
- **APPLY** (one cycle)
  - Load cbu/cbd/vrefcode from the pending registers.
  - Increment upd_cnt (modulo 256).
  - Clear upd_stall.
  - Go to ACK.
- **ACK**
  - cal_ack=1.
  - Stay until cal_vld=0, then go to IDLE (cal_ack=0 from that edge).
- cal_cbu/cal_cbd/cal_vref changes while in WAIT/APPLY/ACK are ignored; pending registers are loaded only in IDLE.
- Simultaneous events:
  - Timer reaching TIMEOUT on the same edge as the quiet condition is met: go to APPLY, upd_stall stays 0.
  - oe or odt_enable rising in the APPLY cycle does not cancel the apply. The decision was made on the prior edge.
- Reset (any time, including mid-WAIT or ACK):
  - Pending codes are discarded and state returns to IDLE.
  - cbu=8'h0F, cbd=8'h0F, vrefcode=8'h80.
  - cal_ack=0, upd_stall=0, upd_busy=0, upd_cnt=0.
  - Quiet counter and timer are cleared.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Edge numbering: E0 is the edge that samples cal_vld=1 in IDLE.
- With idle=1 continuously from E0:
  - Quiet counter reaches QUIET_CYC-1 at edge E(QUIET_CYC-1).
  - State is APPLY after edge E(QUIET_CYC).
  - New codes are on cbu/cbd/vrefcode after edge E(QUIET_CYC+1), when cal_ack also rises.
  - Best-case latency from request to codes: QUIET_CYC+1 cycles.
- Bypass case: cal_ack rises after E0+1 and the codes are unchanged.
- upd_stall rises on the edge where the timer becomes TIMEOUT (the TIMEOUT-th WAIT cycle) and falls on the APPLY edge.
- upd_busy = 1 in WAIT, APPLY and ACK.
- cal_ack falls one edge after cal_vld=0 is sampled in ACK.

## Test plan
- **Reset values:** apply reset with cal_vld=1 -> cbu=0F, cbd=0F, vrefcode=80, cal_ack=0, upd_stall=0, upd_cnt=0; state remains IDLE until reset drops.
- **Quiet apply** (QUIET_CYC=4, oe=odt_enable=0): cal_vld with cbu=3C, cbd=2A, vref=77 -> codes change and cal_ack rises 5 edges after capture; upd_cnt=1; cal_ack falls 1 edge after cal_vld drops.
- **Broken quiet:** same request, oe pulses high on the 3rd WAIT cycle -> counter restarts; codes apply 4 idle cycles after oe falls, never earlier.
- **Timeout** (TIMEOUT=16, oe held high): upd_stall rises on the 16th WAIT cycle; drop oe -> apply 5 edges later and upd_stall falls on the APPLY edge.
- **No-change bypass:** request codes 0F/0F/80 from reset -> cal_ack rises 1 edge after capture, outputs unchanged, upd_cnt=0, no WAIT.
- **Reset mid-WAIT and wrap:** assert reset during WAIT -> outputs return to reset values, pending update lost. Separately, issue 256 distinct updates -> upd_cnt wraps FF->00.
